// File: rtl/idu_seq_ctrl.sv
// Multi-cycle instruction sequencer: IDLE -> IF -> ID -> EX -> (MEM) -> WB, with halt/trap on
// ebreak, decode error or handshake timeout; also keeps cycle and retired-instruction counters.
module idu_seq_ctrl #(
  parameter int LSU_OPT_WIDTH = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ifu_rvalid,
  input  logic [LSU_OPT_WIDTH-1:0] i_lsu_opt,
  input  logic                     i_rdwen,
  input  logic                     i_ebreak,
  input  logic                     i_id_err,
  input  logic                     i_lsu_done,
  output logic                     o_ifu_req,
  output logic                     o_ins_wen,
  output logic                     o_lsu_req,
  output logic                     o_rd_wen,
  output logic                     o_pc_wen,
  output logic                     o_halt,
  output logic                     o_trap,
  output logic [2:0]               o_state,
  output logic [63:0]              o_cycle_cnt,
  output logic [63:0]              o_instret
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_BAD  = 3'd7
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic        trap_set;
  logic        trap_q;
  logic [7:0]  wait_cnt;
  logic [63:0] cycle_cnt;
  logic [63:0] instret;
  logic        lsu_active;
  logic        is_store;

  assign lsu_active = |i_lsu_opt;
  assign is_store   = lsu_active & i_lsu_opt[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    trap_set  = 1'b0;
    o_ifu_req = 1'b0;
    o_ins_wen = 1'b0;
    o_lsu_req = 1'b0;
    o_rd_wen  = 1'b0;
    o_pc_wen  = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_IF;
      S_IF: begin
        o_ifu_req = 1'b1;
        o_ins_wen = i_ifu_rvalid;
        // A handshake in the timeout cycle still wins over the trap.
        if (i_ifu_rvalid) begin
          state_nxt = S_ID;
        end else if (wait_cnt == TIMEOUT_C) begin
          state_nxt = S_HALT;
          trap_set  = 1'b1;
        end
      end
      S_ID: begin
        if (i_id_err) begin
          state_nxt = S_HALT;
          trap_set  = 1'b1;
        end else if (i_ebreak) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EX;
        end
      end
      S_EX: state_nxt = lsu_active ? S_MEM : S_WB;
      S_MEM: begin
        o_lsu_req = 1'b1;
        if (i_lsu_done) begin
          state_nxt = S_WB;
        end else if (wait_cnt == TIMEOUT_C) begin
          state_nxt = S_HALT;
          trap_set  = 1'b1;
        end
      end
      S_WB: begin
        o_pc_wen  = 1'b1;
        o_rd_wen  = i_rdwen & ~is_store;
        state_nxt = S_IF;
      end
      S_HALT: state_nxt = S_HALT;
      default: begin
        state_nxt = S_HALT;
        trap_set  = 1'b1;
      end
    endcase
  end

  // Counter restarts whenever IF/MEM is entered, since any exit clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= 8'd0;
    end else if ((state == S_IF || state == S_MEM) && state_nxt == state) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      trap_q    <= 1'b0;
      cycle_cnt <= 64'd0;
      instret   <= 64'd0;
    end else begin
      trap_q <= trap_q | trap_set;
      if (state != S_HALT) begin
        cycle_cnt <= cycle_cnt + 64'd1;
      end
      if (state == S_WB) begin
        instret <= instret + 64'd1;
      end
    end
  end

  assign o_halt      = (state == S_HALT);
  assign o_trap      = trap_q;
  assign o_state     = state;
  assign o_cycle_cnt = cycle_cnt;
  assign o_instret   = instret;

endmodule

// File: doc/idu_seq_ctrl.md
IDU_SEQ_CTRL -- requirements
Module: idu_seq_ctrl

Interface
REQ-001 Parameter LSU_OPT_WIDTH, default 4: width of i_lsu_opt; value 0 is LSU_NOP, bit0=1 marks a store.
REQ-002 Parameter TIMEOUT, default 255: maximum wait cycles in IF or MEM before trap; range 1..255.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_ifu_rvalid  input  1  fetched instruction valid this cycle.
REQ-006 i_lsu_opt  input  LSU_OPT_WIDTH  decoded LSU opcode of the current instruction.
REQ-007 i_rdwen  input  1  decoded register-write enable of the current instruction.
REQ-008 i_ebreak  input  1  current instruction is ebreak.
REQ-009 i_id_err  input  1  decoder reports an illegal opcode/func3/func7.
REQ-010 i_lsu_done  input  1  LSU access complete this cycle.
REQ-011 o_ifu_req  output  1  fetch request.
REQ-012 o_ins_wen  output  1  instruction-register latch enable.
REQ-013 o_lsu_req  output  1  LSU access request.
REQ-014 o_rd_wen  output  1  gated register-file write enable.
REQ-015 o_pc_wen  output  1  PC update enable.
REQ-016 o_halt  output  1  core halted (sticky).
REQ-017 o_trap  output  1  halt caused by decode error or timeout (sticky).
REQ-018 o_state  output  3  current state encoding.
REQ-019 o_cycle_cnt  output  64  cycles elapsed since reset, excluding HALT.
REQ-020 o_instret  output  64  instructions retired.

Function
REQ-021 States and encoding SHALL be IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6; code 7 SHALL transition to HALT with o_trap set.
REQ-022 IDLE SHALL last exactly one cycle after reset release, then go to IF; all control outputs are 0 in IDLE.
REQ-023 IF: o_ifu_req=1; o_ins_wen = i_ifu_rvalid (same-cycle, combinational); on i_ifu_rvalid go to ID.
REQ-024 ID (one cycle): i_id_err -> HALT with o_trap=1; else i_ebreak -> HALT with o_trap=0; else -> EX; i_id_err has priority over i_ebreak.
REQ-025 EX (one cycle): i_lsu_opt != 0 -> MEM, else -> WB.
REQ-026 MEM: o_lsu_req=1 held continuously until i_lsu_done; on i_lsu_done go to WB.
REQ-027 WB (one cycle): o_pc_wen=1; o_rd_wen = i_rdwen & ~(i_lsu_opt!=0 & i_lsu_opt[0]); o_instret increments by 1; next state IF.
REQ-028 o_rd_wen and o_pc_wen SHALL be 0 in every state other than WB; o_lsu_req is 0 outside MEM; o_ifu_req is 0 outside IF.
REQ-029 An 8-bit wait counter SHALL clear on entry to IF or MEM and increment each cycle spent waiting there.
REQ-030 If the wait counter equals TIMEOUT and the awaited handshake (i_ifu_rvalid / i_lsu_done) is low that cycle, the FSM SHALL go to HALT with o_trap=1; a handshake arriving in that cycle wins.
REQ-031 HALT SHALL be absorbing until reset; o_halt=1, all other control outputs 0, counters frozen.
REQ-032 o_cycle_cnt SHALL increment every cycle in any state except HALT and wraps modulo 2^64; o_instret wraps modulo 2^64.
REQ-033 Minimum latency per non-memory instruction with immediate fetch = 4 cycles (IF, ID, EX, WB); with LSU = 5 + LSU wait cycles.
REQ-034 o_state SHALL reflect the registered state.

Reset
REQ-035 Asserting i_rst SHALL immediately force state=IDLE, o_halt=0, o_trap=0, both 64-bit counters=0, wait counter=0, regardless of current state, including mid-MEM.
REQ-036 All control outputs SHALL be 0 while i_rst is high.

Verification
REQ-037 Reset release, i_ifu_rvalid=1 always, ALU op (lsu_opt=0, rdwen=1) -> states 0,1,2,3,5,1; o_rd_wen and o_pc_wen high only in WB; o_instret=1 after first WB.
REQ-038 Load (lsu_opt=4'b0100, rdwen=1), i_lsu_done after 3 MEM cycles -> o_lsu_req high for exactly 3 cycles, then WB with o_rd_wen=1.
REQ-039 Store (lsu_opt=4'b0101, rdwen=1) -> WB has o_rd_wen=0, o_pc_wen=1.
REQ-040 i_id_err=1 and i_ebreak=1 together in ID -> HALT, o_halt=1, o_trap=1; o_cycle_cnt frozen thereafter.
REQ-041 TIMEOUT=4, i_ifu_rvalid held low -> HALT with o_trap=1 after wait count reaches 4; repeat with rvalid asserted exactly at count 4 -> goes to ID, no trap.
REQ-042 i_rst pulsed mid-MEM -> o_lsu_req drops same cycle, o_state=0, counters 0; normal sequence resumes.
